uart_cmd_router: RTL and testbench
==================================

// Module: uart_cmd_router
// PURPOSE
//  Parametrised successor to the hard-wired UART opcode case decoder. Accepts whole RX frames
//  from uart_top and validates them (byte0 opcode == last-byte trailer). Matches the opcode
//  against a NUM_CH opcode table and hands the payload to the selected channel over a
//  valid/ready handshake. Optionally waits for the channel's response frame, then pulses the
//  UART TX trigger. Adds what the old decoder lacked: backpressure, timeout, NAK replies and
//  an error counter.
// PARAMETERS
//  FRAME_BYTES  18            bytes per frame, >=3; byte0 = frame_data[7:0]
//  NUM_CH       4             number of command channels, 1..16
//  OPCODES      {"D","C","B","A"}  NUM_CH*8 packed opcode table; channel i = OPCODES[8i+:8]
//  RSP_MASK     4'b1001       bit i=1: channel i returns a response frame; 0: fire-and-forget
//  TIMEOUT      1024          cycles allowed from dispatch entry to response, >=2
//  NAK_CHAR     "?"           byte0 of every NAK frame
// PORTS
//  clk          in   1                  system clock
//  reset        in   1                  synchronous, active-high
//  frame_valid  in   1                  RX frame available
//  frame_ready  out  1                  router accepts a frame (IDLE only)
//  frame_data   in   FRAME_BYTES*8      RX frame, byte0 in LSBs
//  cmd_valid    out  NUM_CH             one-hot command request
//  cmd_ready    in   NUM_CH             per-channel accept
//  cmd_payload  out  (FRAME_BYTES-2)*8  bytes 1..FRAME_BYTES-2 of the accepted frame
//  rsp_valid    in   NUM_CH             per-channel response strobe
//  rsp_data     in   NUM_CH*FRAME_BYTES*8  channel i response at [i*FRAME_BYTES*8 +: FRAME_BYTES*8]
//  tx_busy      in   1                  UART TX not ready
//  tx_trigger   out  1                  one-cycle send pulse
//  tx_data      out  FRAME_BYTES*8      frame to transmit, stable from trigger until next SEND
//  err_count    out  8                  saturating error count
// BEHAVIOUR
//  Reset: state IDLE; cmd_valid=0, tx_trigger=0, tx_data=0, cmd_payload=0, err_count=0.
//   frame_ready=0 while reset is high. All outputs are registered except frame_ready=(state==IDLE)&~reset.
//  FSM: IDLE -> CHECK -> DISPATCH -> WAIT_RSP -> SEND -> IDLE.
//  IDLE: frame_valid&frame_ready latches the frame; next state is CHECK.
//  CHECK (1 cycle):
//   - trailer != opcode: drop the frame, err_count+1, return to IDLE; no TX.
//   - no table hit: build NAK {NAK_CHAR, opcode, 0...}, err_count+1, go to SEND.
//   - multiple hits: lowest index wins.
//   - hit: cmd_valid[i]=1 from the next cycle, i.e. accept cycle N -> cmd_valid at N+2.
//  DISPATCH: hold cmd_valid[i] and cmd_payload stable until cmd_ready[i].
//   On handshake, drop cmd_valid the next cycle. If RSP_MASK[i] go to WAIT_RSP, else go to IDLE.
//  Timeout counter clears on DISPATCH entry and counts through DISPATCH and WAIT_RSP.
//   - reaching TIMEOUT-1: cmd_valid=0, NAK {NAK_CHAR, opcode, "T", 0...}, err_count+1, go to SEND.
//   - handshake or rsp_valid[i] in the same cycle as expiry: the handshake/response wins, no NAK.
//  WAIT_RSP: rsp_valid[i] latches slice i into tx_data and goes to SEND.
//   rsp_valid on other channels is ignored.
//  SEND: first cycle with tx_busy=0 -> tx_trigger=1 for exactly that cycle, then IDLE.
//  frame_valid outside IDLE is ignored (not accepted, not counted).
//  err_count saturates at 255.
//  Reset mid-operation: state IDLE next cycle, cmd_valid dropped, no tx_trigger issued.
// STRUCTURE
//  uart_cmd_defs.vh: state encodings, NAK "T" marker, BYTE(frame,n) slice macro.
//  Sub-module uart_cmd_matcher: combinational opcode vs OPCODES table -> hit, index (lowest wins).
//  Top file holds the FSM, frame/payload latches, timeout counter and err_count.
// TESTING  (FRAME_BYTES=18, NUM_CH=4, OPCODES={"D","C","B","A"}, RSP_MASK=4'b1001, TIMEOUT=16)
//  1 "A"+16x"X"+"A"; cmd_ready[0] 2 cycles after cmd_valid; rsp_valid[0] with "{hi_i'm_your_army}"
//    -> cmd_payload=16x"X"; one tx_trigger; tx_data="{hi_i'm_your_army}".
//  2 "A"+16x"X"+"B" -> no cmd_valid, no tx_trigger, err_count=1, frame_ready high 2 cycles after accept.
//  3 "Z"+16x0+"Z" -> tx_data byte0="?", byte1="Z", rest 0; one tx_trigger; err_count+1.
//  4 "D" frame, cmd_ready[3] immediate, no rsp_valid -> NAK byte1="D", byte2="T" exactly
//    16 cycles after DISPATCH entry.
//  5 "B" frame, cmd_ready[1] -> IDLE after handshake, no tx_trigger; concurrent rsp_valid[2] ignored.
//  6 tx_busy high 5 cycles in SEND -> trigger on the first cycle busy=0.
//    Separately, reset during WAIT_RSP -> cmd_valid=0, err_count=0, no tx_trigger.

Source files
------------

// File: rtl/uart_cmd_router_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_router_pkg
// Shared definitions for the UART command router:
//   - FSM state encodings (3-bit, exposed on the router's dbg_state port)
//   - the byte that marks a timeout NAK
//   - a saturating 8-bit increment used by the error counter
// -----------------------------------------------------------------------------
package uart_cmd_router_pkg;

  localparam int STATE_W = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_DISPATCH = 3'd2;
  localparam logic [2:0] ST_WAIT_RSP = 3'd3;
  localparam logic [2:0] ST_SEND     = 3'd4;

  // Third byte of a NAK frame raised because a channel never answered.
  localparam logic [7:0] NAK_TIMEOUT_MARK = "T";

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_router_matcher.sv
// -----------------------------------------------------------------------------
// uart_cmd_router_matcher
// Combinational lookup of an opcode byte in a packed opcode table.
// Channel i owns OPCODES[8i +: 8]. When several entries match, the lowest
// channel index wins.
// Ports:
//   opcode_i  in   8       opcode byte to look up
//   hit_o     out  1       at least one table entry matched
//   idx_o     out  IDX_W   lowest matching channel index (0 when no hit)
// -----------------------------------------------------------------------------
module uart_cmd_router_matcher #(
  parameter int                  NUM_CH  = 4,
  parameter int                  IDX_W   = 2,
  parameter logic [NUM_CH*8-1:0] OPCODES = {"D", "C", "B", "A"}
) (
  input  logic [7:0]       opcode_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the last assignment is the lowest index.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (OPCODES[8*i +: 8] == opcode_i) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_router.sv
// -----------------------------------------------------------------------------
// uart_cmd_router
// Accepts whole UART RX frames, validates them (byte0 opcode must equal the
// last-byte trailer), routes the payload to the channel whose opcode matches,
// optionally waits for that channel's response frame and then pulses the UART
// TX trigger. Unknown opcodes and unanswered commands produce NAK frames;
// malformed frames are dropped. Every error bumps a saturating counter.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   frame_valid   in   RX frame available
//   frame_ready   out  router can accept a frame (IDLE and not in reset)
//   frame_data    in   RX frame, byte0 in the LSBs
//   cmd_valid     out  one-hot command request
//   cmd_ready     in   per-channel accept
//   cmd_payload   out  bytes 1..FRAME_BYTES-2 of the dispatched frame
//   rsp_valid     in   per-channel response strobe
//   rsp_data      in   channel i response at [i*FRAME_BYTES*8 +: FRAME_BYTES*8]
//   tx_busy       in   UART TX cannot take a frame
//   tx_trigger    out  one-cycle send pulse
//   tx_data       out  frame to transmit, held from SEND entry until next SEND
//   err_count     out  saturating error count
//   dbg_state     out  current FSM state (ST_* encodings from the package)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once cmd_valid is raised it stays high, with cmd_payload
// stable, until that transfer (or a timeout withdraws it). frame_valid and
// rsp_valid are only looked at in the states that consume them.
// -----------------------------------------------------------------------------
module uart_cmd_router
  import uart_cmd_router_pkg::*;
#(
  parameter int                  FRAME_BYTES = 18,
  parameter int                  NUM_CH      = 4,
  parameter logic [NUM_CH*8-1:0] OPCODES     = {"D", "C", "B", "A"},
  parameter logic [NUM_CH-1:0]   RSP_MASK    = 4'b1001,
  parameter int                  TIMEOUT     = 1024,
  parameter logic [7:0]          NAK_CHAR    = "?"
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_valid,
  output logic                            frame_ready,
  input  logic [FRAME_BYTES*8-1:0]        frame_data,
  output logic [NUM_CH-1:0]               cmd_valid,
  input  logic [NUM_CH-1:0]               cmd_ready,
  output logic [(FRAME_BYTES-2)*8-1:0]    cmd_payload,
  input  logic [NUM_CH-1:0]               rsp_valid,
  input  logic [NUM_CH*FRAME_BYTES*8-1:0] rsp_data,
  input  logic                            tx_busy,
  output logic                            tx_trigger,
  output logic [FRAME_BYTES*8-1:0]        tx_data,
  output logic [7:0]                      err_count,
  output logic [STATE_W-1:0]              dbg_state
);

  localparam int FW    = FRAME_BYTES * 8;
  localparam int PW    = (FRAME_BYTES - 2) * 8;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0]  cmd_valid_q, cmd_valid_d;
  logic [PW-1:0]      cmd_payload_q, cmd_payload_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]      tx_data_q, tx_data_d;
  logic               tx_trigger_q, tx_trigger_d;
  logic [7:0]         err_q, err_d;

  logic [7:0]         opcode;
  logic [7:0]         trailer;
  logic               m_hit;
  logic [IDX_W-1:0]   m_idx;
  logic               expired;

  assign opcode  = frame_q[7:0];
  assign trailer = frame_q[FW-1 -: 8];
  assign expired = (cnt_q == CNT_LAST);

  uart_cmd_router_matcher #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W),
    .OPCODES(OPCODES)
  ) u_matcher (
    .opcode_i(opcode),
    .hit_o   (m_hit),
    .idx_o   (m_idx)
  );

  // NAK frame: {NAK_CHAR, opcode, code, zeros...}; code is 0 for an unknown
  // opcode and NAK_TIMEOUT_MARK for a channel that never answered.
  function automatic logic [FW-1:0] nak_frame(input logic [7:0] op,
                                              input logic [7:0] code);
    logic [FW-1:0] f;
    f        = '0;
    f[7:0]   = NAK_CHAR;
    f[15:8]  = op;
    f[23:16] = code;
    return f;
  endfunction

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    idx_d         = idx_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_payload_d = cmd_payload_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_trigger_d  = 1'b0;
    err_d         = err_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_valid && frame_ready) begin
          frame_d = frame_data;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (trailer != opcode) begin
          err_d   = sat_inc8(err_q);
          state_d = ST_IDLE;
        end else if (!m_hit) begin
          tx_data_d = nak_frame(opcode, 8'h00);
          err_d     = sat_inc8(err_q);
          state_d   = ST_SEND;
        end else begin
          idx_d         = m_idx;
          cmd_valid_d   = NUM_CH'(1) << m_idx;
          cmd_payload_d = frame_q[8 +: PW];
          cnt_d         = '0;
          state_d       = ST_DISPATCH;
        end
      end

      // The counter stops at CNT_LAST: a handshake that lands on the expiry
      // cycle still wins, and WAIT_RSP then times out on its very next cycle
      // unless the response is already there.
      ST_DISPATCH: begin
        if (!expired) cnt_d = cnt_q + CNT_W'(1);
        if (cmd_ready[idx_q]) begin
          cmd_valid_d = '0;
          state_d     = RSP_MASK[idx_q] ? ST_WAIT_RSP : ST_IDLE;
        end else if (expired) begin
          cmd_valid_d = '0;
          tx_data_d   = nak_frame(opcode, NAK_TIMEOUT_MARK);
          err_d       = sat_inc8(err_q);
          state_d     = ST_SEND;
        end
      end

      ST_WAIT_RSP: begin
        if (!expired) cnt_d = cnt_q + CNT_W'(1);
        if (rsp_valid[idx_q]) begin
          tx_data_d = rsp_data[int'(idx_q) * FW +: FW];
          state_d   = ST_SEND;
        end else if (expired) begin
          tx_data_d = nak_frame(opcode, NAK_TIMEOUT_MARK);
          err_d     = sat_inc8(err_q);
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_trigger_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_q       <= '0;
      idx_q         <= '0;
      cmd_valid_q   <= '0;
      cmd_payload_q <= '0;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      tx_trigger_q  <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      idx_q         <= idx_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_payload_q <= cmd_payload_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_trigger_q  <= tx_trigger_d;
      err_q         <= err_d;
    end
  end

  assign frame_ready = (state_q == ST_IDLE) & ~reset;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_payload = cmd_payload_q;
  assign tx_trigger  = tx_trigger_q;
  assign tx_data     = tx_data_q;
  assign err_count   = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_cmd_router.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_router
// Directed bench for uart_cmd_router with FRAME_BYTES=18, NUM_CH=4,
// OPCODES={"D","C","B","A"}, RSP_MASK=4'b1001, TIMEOUT=16, NAK_CHAR="?".
// Expected TX frames are queued when the stimulus that causes them is driven
// and checked by a monitor on every tx_trigger pulse.
// -----------------------------------------------------------------------------
module tb_uart_cmd_router;
  import uart_cmd_router_pkg::*;

  localparam int FB  = 18;
  localparam int NCH = 4;
  localparam int FW  = FB * 8;
  localparam int PW  = (FB - 2) * 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_valid;
  logic              frame_ready;
  logic [FW-1:0]     frame_data;
  logic [NCH-1:0]    cmd_valid;
  logic [NCH-1:0]    cmd_ready;
  logic [PW-1:0]     cmd_payload;
  logic [NCH-1:0]    rsp_valid;
  logic [NCH*FW-1:0] rsp_data;
  logic              tx_busy;
  logic              tx_trigger;
  logic [FW-1:0]     tx_data;
  logic [7:0]        err_count;
  logic [2:0]        dbg_state;

  int n_vec  = 0;
  int n_err  = 0;
  int n_trig = 0;
  int n_cmdv = 0;

  logic [FW-1:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  uart_cmd_router #(
    .FRAME_BYTES(FB),
    .NUM_CH     (NCH),
    .OPCODES    ({"D", "C", "B", "A"}),
    .RSP_MASK   (4'b1001),
    .TIMEOUT    (16),
    .NAK_CHAR   ("?")
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data (frame_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_payload(cmd_payload),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .tx_busy    (tx_busy),
    .tx_trigger (tx_trigger),
    .tx_data    (tx_data),
    .err_count  (err_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [FW-1:0] obs,
                       input logic [FW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] make_frame(input logic [7:0] op,
                                               input logic [7:0] fill,
                                               input logic [7:0] trl);
    logic [FW-1:0] f;
    f = '0;
    f[7:0] = op;
    for (int b = 1; b < FB - 1; b++) f[8*b +: 8] = fill;
    f[FW-1 -: 8] = trl;
    return f;
  endfunction

  // Present one frame; returns at the negedge after the accepting edge.
  task automatic send_frame(input logic [FW-1:0] f);
    int w;
    w = 0;
    while (frame_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("frame_ready_wait", (w < 50), 1'b1);
    frame_valid = 1'b1;
    frame_data  = f;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (tx_trigger === 1'b1) begin
      n_trig++;
      if (exp_q.size() == 0) check("tx_unexpected", 1'b1, 1'b0);
      else check("tx_data", tx_data, exp_q.pop_front());
    end
    if (cmd_valid !== '0) n_cmdv++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [FW-1:0] f, rsp, e;
    logic [7:0]    fill;
    int            t0, c0, k;

    reset = 1'b1; frame_valid = 1'b0; frame_data = '0; cmd_ready = '0;
    rsp_valid = '0; rsp_data = '0; tx_busy = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_frame_ready", frame_ready, 1'b0);
    check("rst_cmd_valid", cmd_valid, '0);
    check("rst_tx_trigger", tx_trigger, 1'b0);
    check("rst_tx_data", tx_data, '0);
    check("rst_payload", cmd_payload, '0);
    check("rst_err", err_count, 8'd0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    @(negedge clk);
    check("idle_frame_ready", frame_ready, 1'b1);

    // 1: "A" command with response; frame_valid during DISPATCH is ignored
    t0 = n_trig;
    send_frame(make_frame("A", "X", "A"));
    check("t1_state_check", dbg_state, ST_CHECK);
    @(negedge clk);
    check("t1_cmd_valid", cmd_valid, 4'b0001);
    check("t1_payload", cmd_payload, {16{8'h58}});
    check("t1_ready_low", frame_ready, 1'b0);
    frame_valid = 1'b1;
    frame_data  = make_frame("A", "Q", "B");
    @(negedge clk);
    frame_valid = 1'b0;
    check("t1_cmd_hold", cmd_valid, 4'b0001);
    check("t1_payload_hold", cmd_payload, {16{8'h58}});
    @(negedge clk);
    cmd_ready = 4'b0001;
    @(negedge clk);
    cmd_ready = '0;
    check("t1_cmd_drop", cmd_valid, '0);
    check("t1_state_wait", dbg_state, ST_WAIT_RSP);
    rsp = "{hi_i'm_your_army}";
    exp_q.push_back(rsp);
    rsp_data[0 +: FW] = rsp;
    rsp_valid = 4'b0001;
    @(negedge clk);
    rsp_valid = '0;
    check("t1_state_send", dbg_state, ST_SEND);
    repeat (3) @(negedge clk);
    check("t1_one_tx", n_trig - t0, 1);
    check("t1_err", err_count, 8'd0);

    // 2: trailer mismatch -> dropped
    t0 = n_trig; c0 = n_cmdv;
    send_frame(make_frame("A", "X", "B"));
    check("t2_ready_in_check", frame_ready, 1'b0);
    @(negedge clk);
    check("t2_ready_back", frame_ready, 1'b1);
    check("t2_err", err_count, 8'd1);
    repeat (3) @(negedge clk);
    check("t2_no_cmd", n_cmdv - c0, 0);
    check("t2_no_tx", n_trig - t0, 0);

    // 3: unknown opcode -> NAK
    t0 = n_trig; c0 = n_cmdv;
    e = '0; e[7:0] = "?"; e[15:8] = "Z";
    exp_q.push_back(e);
    send_frame(make_frame("Z", 8'h00, "Z"));
    repeat (4) @(negedge clk);
    check("t3_one_tx", n_trig - t0, 1);
    check("t3_no_cmd", n_cmdv - c0, 0);
    check("t3_err", err_count, 8'd2);

    // 4: "D" accepted at once but never answered -> timeout NAK
    t0 = n_trig;
    e = '0; e[7:0] = "?"; e[15:8] = "D"; e[23:16] = "T";
    exp_q.push_back(e);
    cmd_ready = 4'b1000;
    send_frame(make_frame("D", "X", "D"));
    @(negedge clk);
    check("t4_cmd_valid", cmd_valid, 4'b1000);
    k = 0;
    while (tx_data[23:16] !== 8'h54 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        cmd_ready = '0;
        check("t4_state_wait", dbg_state, ST_WAIT_RSP);
      end
    end
    check("t4_nak_latency", k, 16);
    check("t4_err", err_count, 8'd3);
    repeat (3) @(negedge clk);
    check("t4_one_tx", n_trig - t0, 1);

    // 5: fire-and-forget "B"; a response on channel 2 is ignored
    t0 = n_trig;
    fill = 8'($urandom_range(33, 126));
    cmd_ready = 4'b0010;
    rsp_data[2*FW +: FW] = {9{16'($urandom)}};
    rsp_valid = 4'b0100;
    send_frame(make_frame("B", fill, "B"));
    @(negedge clk);
    check("t5_cmd_valid", cmd_valid, 4'b0010);
    check("t5_payload", cmd_payload, {16{fill}});
    @(negedge clk);
    cmd_ready = '0;
    check("t5_cmd_drop", cmd_valid, '0);
    check("t5_state_idle", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    rsp_valid = '0;
    check("t5_no_tx", n_trig - t0, 0);
    check("t5_tx_data_kept", tx_data, e);

    // 6: other-channel response ignored in WAIT_RSP, then tx_busy in SEND
    t0 = n_trig;
    cmd_ready = 4'b0001;
    send_frame(make_frame("A", "X", "A"));
    repeat (2) @(negedge clk);
    cmd_ready = '0;
    check("t6_state_wait", dbg_state, ST_WAIT_RSP);
    rsp_valid = 4'b0100;
    repeat (2) @(negedge clk);
    check("t6_other_rsp_ignored", dbg_state, ST_WAIT_RSP);
    for (int b = 0; b < FB; b++) rsp[8*b +: 8] = 8'($urandom_range(0, 255));
    exp_q.push_back(rsp);
    rsp_data[0 +: FW] = rsp;
    rsp_valid = 4'b0001;
    tx_busy = 1'b1;
    @(negedge clk);
    rsp_valid = '0;
    for (int i = 0; i < 5; i++) begin
      check("t6_busy_state", dbg_state, ST_SEND);
      check("t6_busy_no_trigger", tx_trigger, 1'b0);
      @(negedge clk);
    end
    tx_busy = 1'b0;
    check("t6_still_send", dbg_state, ST_SEND);
    @(negedge clk);
    check("t6_trigger", tx_trigger, 1'b1);
    check("t6_state_idle", dbg_state, ST_IDLE);
    @(negedge clk);
    check("t6_trigger_pulse", tx_trigger, 1'b0);
    check("t6_one_tx", n_trig - t0, 1);

    // reset while waiting for a response
    t0 = n_trig;
    cmd_ready = 4'b0001;
    send_frame(make_frame("A", "X", "A"));
    repeat (2) @(negedge clk);
    cmd_ready = '0;
    check("r_state_wait", dbg_state, ST_WAIT_RSP);
    check("r_err_before", err_count, 8'd3);
    reset = 1'b1;
    @(negedge clk);
    check("r_state_idle", dbg_state, ST_IDLE);
    check("r_cmd_valid", cmd_valid, '0);
    check("r_err", err_count, 8'd0);
    check("r_ready_in_reset", frame_ready, 1'b0);
    rsp_valid = 4'b0001;
    reset = 1'b0;
    @(negedge clk);
    rsp_valid = '0;
    check("r_ready_after", frame_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("r_no_tx", n_trig - t0, 0);

    // error counter saturation
    for (int i = 0; i < 258; i++) begin
      send_frame(make_frame("C", 8'(i), "A"));
      @(negedge clk);
      if (i == 253) check("sat_254", err_count, 8'd254);
    end
    check("sat_255", err_count, 8'd255);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
